// File: rtl/armleocpu_loadunit.sv
// Load unit: takes one load from execute, does a single aligned 32-bit bus read,
// extracts and extends the addressed byte/halfword/word and returns it to writeback.
module armleocpu_loadunit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_type,

  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rerror,

  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_missaligned,
  output logic        resp_accessfault
);

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [1:0]  ld_off;
  logic [2:0]  ld_type;
  logic [7:0]  to_cnt;
  logic        req_bad;
  logic        timeout_hit;
  logic        req_fire;
  logic        addr_fire;
  logic        resp_fire;

  function automatic logic type_illegal(input logic [2:0] t);
    return !(t == LD_B || t == LD_H || t == LD_W || t == LD_BU || t == LD_HU);
  endfunction

  function automatic logic addr_misaligned(input logic [2:0] t, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (t == LD_W && off != 2'b00)
      bad = 1'b1;
    if ((t == LD_H || t == LD_HU) && off[0])
      bad = 1'b1;
    return bad;
  endfunction

  // Lane select by shifting the word down, then extend from the requested width.
  function automatic logic [31:0] extract(input logic [31:0] rdata, input logic [1:0] off,
                                          input logic [2:0] t);
    logic [4:0]         sh_amt;
    logic [31:0]        sh;
    logic signed [7:0]  b8;
    logic signed [15:0] h16;
    logic [31:0]        res;
    sh_amt = {off, 3'b000};
    sh     = rdata >> sh_amt;
    b8     = sh[7:0];
    h16    = sh[15:0];
    case (t)
      LD_B:    res = {{24{b8[7]}}, b8};
      LD_BU:   res = {24'h0, sh[7:0]};
      LD_H:    res = {{16{h16[15]}}, h16};
      LD_HU:   res = {16'h0, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  assign req_bad     = type_illegal(req_type) || addr_misaligned(req_type, req_addr[1:0]);
  assign timeout_hit = (to_cnt == TO_LAST) && !mem_rvalid;
  assign req_fire    = (state == IDLE)  && req_valid;
  assign addr_fire   = (state == ISSUE) && mem_ready;
  assign resp_fire   = (state == RESP)  && resp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    mem_valid  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_nxt = req_bad ? RESP : ISSUE;
      end
      ISSUE: begin
        mem_valid = 1'b1;
        if (mem_ready)
          state_nxt = WAIT;
      end
      WAIT: begin
        if (mem_rvalid || timeout_hit)
          state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_off           <= 2'b00;
      ld_type          <= 3'b000;
      mem_addr         <= 32'h0;
      to_cnt           <= 8'h0;
      resp_data        <= 32'h0;
      resp_missaligned <= 1'b0;
      resp_accessfault <= 1'b0;
    end else begin
      if (req_fire) begin
        ld_off   <= req_addr[1:0];
        ld_type  <= req_type;
        mem_addr <= {req_addr[31:2], 2'b00};
        if (req_bad) begin
          resp_data        <= 32'h0;
          resp_missaligned <= 1'b1;
          resp_accessfault <= 1'b0;
        end
      end

      if (addr_fire)
        to_cnt <= 8'h0;
      else if (state == WAIT && !mem_rvalid && !timeout_hit)
        to_cnt <= to_cnt + 8'h1;

      // Bus error and timeout both report as an access fault with zero data.
      if (state == WAIT) begin
        if (mem_rvalid && !mem_rerror) begin
          resp_data        <= extract(mem_rdata, ld_off, ld_type);
          resp_missaligned <= 1'b0;
          resp_accessfault <= 1'b0;
        end else if (mem_rvalid || timeout_hit) begin
          resp_data        <= 32'h0;
          resp_missaligned <= 1'b0;
          resp_accessfault <= 1'b1;
        end
      end

      if (resp_fire) begin
        resp_missaligned <= 1'b0;
        resp_accessfault <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_armleocpu_loadunit.sv
// Directed bench for armleocpu_loadunit: aligned loads, misaligned/illegal requests,
// bus stalls and errors, timeout and asynchronous reset mid-transaction.
module tb_armleocpu_loadunit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic [2:0]  req_type = 3'b000;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_rerror = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        resp_missaligned;
  logic        resp_accessfault;

  int n_pass  = 0;
  int n_total = 0;
  int mv_cycles = 0;

  armleocpu_loadunit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_type(req_type),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rerror(mem_rerror),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_missaligned(resp_missaligned), .resp_accessfault(resp_accessfault)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_valid) mv_cycles++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [31:0] addr, input logic [2:0] t);
    req_valid = 1'b1;
    req_addr  = addr;
    req_type  = t;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic finish_resp(input string tag, input logic [31:0] exp_data);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, " resp_valid drop"}, {31'h0, resp_valid}, 32'h0);
    check({tag, " req_ready back"}, {31'h0, req_ready}, 32'h1);
    check({tag, " data held"}, resp_data, exp_data);
    check({tag, " flags cleared"}, {30'h0, resp_missaligned, resp_accessfault}, 32'h0);
  endtask

  task automatic normal_load(input string tag, input logic [31:0] addr, input logic [2:0] t,
                             input logic [31:0] rdata, input logic [31:0] exp);
    send_req(addr, t);
    check({tag, " mem_valid"}, {31'h0, mem_valid}, 32'h1);
    check({tag, " mem_addr"}, mem_addr, {addr[31:2], 2'b00});
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check({tag, " wait no mem_valid"}, {31'h0, mem_valid}, 32'h0);
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    mem_rerror = 1'b0;
    tick();
    mem_rvalid = 1'b0;
    check({tag, " resp_valid"}, {31'h0, resp_valid}, 32'h1);
    check({tag, " resp_data"}, resp_data, exp);
    check({tag, " flags"}, {30'h0, resp_missaligned, resp_accessfault}, 32'h0);
    finish_resp(tag, exp);
  endtask

  task automatic bad_req(input string tag, input logic [31:0] addr, input logic [2:0] t);
    int mv0;
    mv0 = mv_cycles;
    send_req(addr, t);
    check({tag, " resp_valid"}, {31'h0, resp_valid}, 32'h1);
    check({tag, " missaligned"}, {31'h0, resp_missaligned}, 32'h1);
    check({tag, " accessfault"}, {31'h0, resp_accessfault}, 32'h0);
    check({tag, " resp_data"}, resp_data, 32'h0);
    tick();
    check({tag, " held"}, {31'h0, resp_valid}, 32'h1);
    finish_resp(tag, 32'h0);
    check({tag, " no bus cycle"}, 32'(mv_cycles - mv0), 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"}, {31'h0, req_ready}, 32'h1);
    check({tag, " mem_valid"}, {31'h0, mem_valid}, 32'h0);
    check({tag, " mem_addr"}, mem_addr, 32'h0);
    check({tag, " resp_valid"}, {31'h0, resp_valid}, 32'h0);
    check({tag, " resp_data"}, resp_data, 32'h0);
    check({tag, " flags"}, {30'h0, resp_missaligned, resp_accessfault}, 32'h0);
  endtask

  initial begin
    #3;
    check_reset_outputs("reset");
    #10 rst_n = 1'b1;
    tick();

    normal_load("lb",  32'h0000_1003, 3'b000, 32'h80AA55CC, 32'hFFFFFF80);
    normal_load("lbu", 32'h0000_1003, 3'b100, 32'h80AA55CC, 32'h00000080);
    normal_load("lb1", 32'h0000_1001, 3'b000, 32'h80AA55CC, 32'h00000055);
    normal_load("lh",  32'h0000_2002, 3'b001, 32'h8001FFFF, 32'hFFFF8001);
    normal_load("lhu", 32'h0000_2002, 3'b101, 32'h8001FFFF, 32'h00008001);
    normal_load("lh0", 32'h0000_2000, 3'b001, 32'h8001FFFF, 32'hFFFFFFFF);
    normal_load("lw",  32'h0000_2000, 3'b010, 32'hDEADBEEF, 32'hDEADBEEF);

    bad_req("lw_mis", 32'h0000_3002, 3'b010);
    bad_req("lh_mis", 32'h0000_3001, 3'b001);
    bad_req("ill011", 32'h0000_3000, 3'b011);

    // Address stall followed by a bus error, then a consumer stall.
    send_req(32'h0000_4004, 3'b010);
    for (int i = 0; i < 5; i++) begin
      check("stall mem_valid", {31'h0, mem_valid}, 32'h1);
      check("stall mem_addr", mem_addr, 32'h0000_4004);
      tick();
    end
    mem_ready = 1'b1;
    tick();
    mem_ready  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rerror = 1'b1;
    mem_rdata  = 32'h12345678;
    tick();
    mem_rvalid = 1'b0;
    mem_rerror = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("err resp_valid", {31'h0, resp_valid}, 32'h1);
      check("err accessfault", {31'h0, resp_accessfault}, 32'h1);
      check("err missaligned", {31'h0, resp_missaligned}, 32'h0);
      check("err resp_data", resp_data, 32'h0);
      tick();
    end
    finish_resp("err", 32'h0);

    // Timeout: four WAIT cycles without rvalid.
    send_req(32'h0000_5000, 3'b010);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    tick();
    check("to not yet", {31'h0, resp_valid}, 32'h0);
    tick();
    check("to resp_valid", {31'h0, resp_valid}, 32'h1);
    check("to accessfault", {31'h0, resp_accessfault}, 32'h1);
    check("to resp_data", resp_data, 32'h0);
    finish_resp("to", 32'h0);
    normal_load("after_to", 32'h0000_5008, 3'b010, 32'hCAFEF00D, 32'hCAFEF00D);

    // Asynchronous reset while waiting for read data.
    send_req(32'h0000_6000, 3'b010);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_wait");
    #10 rst_n = 1'b1;
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h11111111;
    tick();
    mem_rvalid = 1'b0;
    check("rst late rvalid", {31'h0, resp_valid}, 32'h0);
    check("rst late data", resp_data, 32'h0);
    normal_load("after_rst", 32'h0000_6002, 3'b101, 32'hA5A5C3C3, 32'h0000A5A5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
